led_cube_uart_sequencer: RTL and testbench

Avalon-MM master sequencer that owns the single master port into the UART core and shares it between the RX path and the TX path. It polls the UART status register, fetches received bytes for the LED cube driver, and writes queued TX bytes (acks/echo). It also clears receive-overrun errors. It sits between the UART slave and the cube's byte consumer, replacing ad-hoc polling with an explicit arbitrated schedule.

---
 rtl/led_cube_uart_sequencer.sv | 158 +++++++++++++++
 tb/tb_led_cube_uart_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_cube_uart_sequencer.sv
// Avalon-MM master that shares one UART slave port between status polling,
// RX byte fetches, TX byte writes and receive-overrun clears.
module led_cube_uart_sequencer #(
    parameter int POLL_GAP = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [4:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [15:0] avm_writedata,
    input  logic [15:0] avm_readdata,
    input  logic        avm_readdatavalid,
    input  logic        avm_waitrequest,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  ovf_count,
    output logic        err_timeout,
    output logic        busy
);
    localparam logic [4:0] A_RXDATA = 5'h00;
    localparam logic [4:0] A_TXDATA = 5'h04;
    localparam logic [4:0] A_STATUS = 5'h08;
    localparam logic [7:0] LP_GAP   = 8'(POLL_GAP);
    localparam logic [7:0] LP_TMO   = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ST_RD, ST_WT, RX_RD, RX_WT, TX_WR, CLR_WR} state_t;

    state_t      r_state, w_next;
    logic [7:0]  r_gap, r_wait, r_tx_buf;
    logic        r_tx_pend, r_clr_pend, r_last_tx;
    logic        w_rx_req, w_tx_req, w_status, w_rx_done, w_timeout, w_tx_acc, w_clr_acc;
    logic [4:0]  w_addr;
    logic        w_rd, w_wr;
    logic [15:0] w_wd;
    logic        w_unused;

    assign w_unused  = ^avm_readdata[15:8];
    assign w_rx_req  = avm_readdata[7];
    assign w_tx_req  = avm_readdata[6] & r_tx_pend;
    assign w_tx_acc  = (r_state == TX_WR)  && !avm_waitrequest;
    assign w_clr_acc = (r_state == CLR_WR) && !avm_waitrequest;
    assign tx_ready  = ~r_tx_pend;
    assign busy      = (r_state != IDLE);

    always_comb begin
        w_next    = r_state;
        w_status  = 1'b0;
        w_rx_done = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE:   if (r_gap == LP_GAP && enable) w_next = ST_RD;
            ST_RD:  if (!avm_waitrequest) w_next = ST_WT;
            ST_WT: begin
                if (avm_readdatavalid) begin
                    w_status = 1'b1;
                    // On a tie, RX wins unless RX was granted last.
                    if (w_rx_req && (!w_tx_req || r_last_tx)) w_next = RX_RD;
                    else if (w_tx_req)                        w_next = TX_WR;
                    else                                      w_next = IDLE;
                end else if (r_wait == LP_TMO) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            RX_RD:  if (!avm_waitrequest) w_next = RX_WT;
            RX_WT: begin
                if (avm_readdatavalid) begin
                    w_rx_done = 1'b1;
                    w_next    = r_clr_pend ? CLR_WR : IDLE;
                end else if (r_wait == LP_TMO) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            TX_WR:  if (!avm_waitrequest) w_next = r_clr_pend ? CLR_WR : IDLE;
            CLR_WR: if (!avm_waitrequest) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they hold during stalls.
    always_comb begin
        w_addr = A_RXDATA;
        w_rd   = 1'b0;
        w_wr   = 1'b0;
        w_wd   = 16'h0000;
        case (w_next)
            ST_RD:  begin w_addr = A_STATUS; w_rd = 1'b1; end
            RX_RD:  begin w_addr = A_RXDATA; w_rd = 1'b1; end
            TX_WR:  begin w_addr = A_TXDATA; w_wr = 1'b1; w_wd = {8'h00, r_tx_buf}; end
            CLR_WR: begin w_addr = A_STATUS; w_wr = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            avm_address   <= 5'h00;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= 16'h0000;
        end else begin
            r_state       <= w_next;
            avm_address   <= w_addr;
            avm_read      <= w_rd;
            avm_write     <= w_wr;
            avm_writedata <= w_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap       <= 8'h00;
            r_wait      <= 8'h00;
            r_tx_buf    <= 8'h00;
            r_tx_pend   <= 1'b0;
            r_clr_pend  <= 1'b0;
            r_last_tx   <= 1'b1;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            ovf_count   <= 8'h00;
            err_timeout <= 1'b0;
        end else begin
            if (r_state == IDLE && w_next == IDLE)
                r_gap <= (r_gap == LP_GAP) ? r_gap : r_gap + 8'h01;
            else
                r_gap <= 8'h00;
            r_wait <= (w_next != r_state) ? 8'h00 : r_wait + 8'h01;

            if (w_tx_acc) r_tx_pend <= 1'b0;
            else if (tx_valid && !r_tx_pend) begin
                r_tx_pend <= 1'b1;
                r_tx_buf  <= tx_data;
            end

            if (w_rx_done)     r_last_tx <= 1'b0;
            else if (w_tx_acc) r_last_tx <= 1'b1;

            if (w_status && avm_readdata[3]) begin
                r_clr_pend <= 1'b1;
                if (ovf_count != 8'hFF) ovf_count <= ovf_count + 8'h01;
            end else if (w_clr_acc) begin
                r_clr_pend <= 1'b0;
            end

            if (w_timeout) err_timeout <= 1'b1;
            rx_valid <= w_rx_done;
            if (w_rx_done) rx_data <= avm_readdata[7:0];
        end
    end
endmodule

// File: tb/tb_led_cube_uart_sequencer.sv
// Directed bench: a small UART slave model answers the sequencer and logs
// every accepted access; each task checks its scenario against hand values.
module tb_led_cube_uart_sequencer;
    localparam int PG  = 4;
    localparam int TMO = 16;

    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
    logic [4:0]  avm_address;
    logic        avm_read, avm_write;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata = 16'h0000;
    logic        avm_readdatavalid = 1'b0, avm_waitrequest = 1'b0;
    logic [7:0]  rx_data, tx_data = 8'h00, ovf_count;
    logic        rx_valid, tx_valid = 1'b0, tx_ready, err_timeout, busy;

    led_cube_uart_sequencer #(.POLL_GAP(PG), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .ovf_count(ovf_count), .err_timeout(err_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_tot = 0;

    // slave model state
    int          cyc = 0, slv_wait = 0, ws_cnt = 0, drop_cyc = 0;
    bit          slv_drop = 1'b0, rdv_due = 1'b0, prev_wait = 1'b0;
    logic [15:0] slv_status = 16'h0040, slv_rxdata = 16'h0000, rdv_data = 16'h0000;
    logic [15:0] stat_q[$];
    logic [22:0] prev_bus = '0;
    int          stab_err = 0, both_err = 0;
    int          rx_pulses = 0, rxv_run = 0, rxv_max = 0, rx_last_cyc = 0;
    logic [3:0]  hist [0:65535];  // {rx_valid, err_timeout, tx_ready, busy}
    int          log_cyc[$];
    logic [4:0]  log_addr[$];
    bit          log_wr[$];
    logic [15:0] log_data[$];
    int          log_ws[$];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic slave_proc();
        logic [15:0] d;
        forever begin
            @(negedge clk);
            cyc++;
            hist[cyc] = {rx_valid, err_timeout, tx_ready, busy};
            if (rx_valid) begin
                rxv_run++;
                if (rxv_run == 1) begin rx_pulses++; rx_last_cyc = cyc; end
                if (rxv_run > rxv_max) rxv_max = rxv_run;
            end else rxv_run = 0;
            if (rdv_due) begin
                avm_readdatavalid = 1'b1; avm_readdata = rdv_data; rdv_due = 1'b0;
            end else begin
                avm_readdatavalid = 1'b0; avm_readdata = 16'hDEAD;
            end
            if (rst_n && prev_wait && ({avm_address, avm_read, avm_write, avm_writedata} !== prev_bus))
                stab_err++;
            if (avm_read && avm_write) both_err++;
            if (avm_read || avm_write) begin
                if (ws_cnt < slv_wait) begin
                    avm_waitrequest = 1'b1; ws_cnt++;
                end else begin
                    avm_waitrequest = 1'b0;
                    d = avm_writedata;
                    if (avm_read) begin
                        if (avm_address != 5'h08) d = slv_rxdata;
                        else if (stat_q.size() > 0) d = stat_q.pop_front();
                        else d = slv_status;
                        if (slv_drop) begin slv_drop = 1'b0; drop_cyc = cyc; end
                        else begin rdv_due = 1'b1; rdv_data = d; end
                    end
                    log_cyc.push_back(cyc); log_addr.push_back(avm_address);
                    log_wr.push_back(avm_write); log_data.push_back(d); log_ws.push_back(ws_cnt);
                    ws_cnt = 0;
                end
            end else begin
                avm_waitrequest = 1'b0; ws_cnt = 0;
            end
            prev_wait = avm_waitrequest;
            prev_bus  = {avm_address, avm_read, avm_write, avm_writedata};
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; enable = 1'b1; slv_status = 16'h0040;
        repeat (3) tick();
        n_tot++; if (avm_address !== 5'h00) $display("FAIL rst_address got %0h exp 0", avm_address); else n_pass++;
        n_tot++; if (avm_read !== 1'b0) $display("FAIL rst_read got %0b exp 0", avm_read); else n_pass++;
        n_tot++; if (avm_write !== 1'b0) $display("FAIL rst_write got %0b exp 0", avm_write); else n_pass++;
        n_tot++; if (avm_writedata !== 16'h0) $display("FAIL rst_wdata got %0h exp 0", avm_writedata); else n_pass++;
        n_tot++; if (rx_data !== 8'h00) $display("FAIL rst_rx_data got %0h exp 0", rx_data); else n_pass++;
        n_tot++; if (rx_valid !== 1'b0) $display("FAIL rst_rx_valid got %0b exp 0", rx_valid); else n_pass++;
        n_tot++; if (tx_ready !== 1'b1) $display("FAIL rst_tx_ready got %0b exp 1", tx_ready); else n_pass++;
        n_tot++; if (ovf_count !== 8'h00) $display("FAIL rst_ovf got %0h exp 0", ovf_count); else n_pass++;
        n_tot++; if (err_timeout !== 1'b0) $display("FAIL rst_err got %0b exp 0", err_timeout); else n_pass++;
        n_tot++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b exp 0", busy); else n_pass++;
        rst_n = 1'b1;
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1; n++;
            if (avm_read === 1'b1) break;
        end
        n_tot++; if (n != PG + 1) $display("FAIL first_read_latency got %0d exp %0d", n, PG + 1); else n_pass++;
        n_tot++; if (busy !== 1'b1) $display("FAIL first_read_busy got %0b exp 1", busy); else n_pass++;
    endtask

    task automatic test_idle_poll();
        int lb, t, n0;
        logic [6:0] bz;
        lb = log_cyc.size(); t = 0;
        while (log_cyc.size() < lb + 4 && t < 60) begin tick(); t++; end
        n_tot++;
        if (log_cyc.size() < lb + 4) $display("FAIL idle_polls got %0d exp 4", log_cyc.size() - lb);
        else begin
            n_pass++;
            for (int i = 0; i < 4; i++) begin
                n_tot++;
                if ({log_wr[lb+i], log_addr[lb+i]} !== {1'b0, 5'h08})
                    $display("FAIL idle_access%0d got wr=%0b addr=%0h exp read 08", i, log_wr[lb+i], log_addr[lb+i]);
                else n_pass++;
            end
            for (int i = 1; i < 4; i++) begin
                n_tot++;
                if (log_cyc[lb+i] - log_cyc[lb+i-1] != PG + 3)
                    $display("FAIL idle_period%0d got %0d exp %0d", i, log_cyc[lb+i] - log_cyc[lb+i-1], PG + 3);
                else n_pass++;
            end
            for (int i = 0; i < 7; i++) bz[6-i] = hist[log_cyc[lb] + i][0];
            n_tot++; if (bz !== 7'b1100000) $display("FAIL idle_busy_pattern got %b exp 1100000", bz); else n_pass++;
        end
        enable = 1'b0;
        repeat (4) tick();
        n0 = log_cyc.size();
        repeat (20) tick();
        n_tot++; if (log_cyc.size() != n0) $display("FAIL disable_no_polls got %0d exp 0", log_cyc.size() - n0); else n_pass++;
        n_tot++; if (busy !== 1'b0) $display("FAIL disable_busy got %0b exp 0", busy); else n_pass++;
        enable = 1'b1;
    endtask

    task automatic test_rx_fetch();
        int lb, t, p0, k;
        lb = log_cyc.size(); p0 = rx_pulses; rxv_max = 0; t = 0; k = -1;
        slv_rxdata = 16'h005A;
        stat_q.push_back(16'h0080);
        while (rx_pulses == p0 && t < 60) begin tick(); t++; end
        repeat (3) tick();
        n_tot++; if (rx_pulses != p0 + 1) $display("FAIL rx_pulse_count got %0d exp %0d", rx_pulses, p0 + 1); else n_pass++;
        n_tot++; if (rx_data !== 8'h5A) $display("FAIL rx_data got %0h exp 5a", rx_data); else n_pass++;
        n_tot++; if (rxv_max != 1) $display("FAIL rx_valid_width got %0d exp 1", rxv_max); else n_pass++;
        for (int i = lb; i < log_cyc.size(); i++)
            if (k < 0 && !log_wr[i] && log_addr[i] == 5'h08 && log_data[i] == 16'h0080) k = i;
        n_tot++;
        if (k < 0 || k + 1 >= log_cyc.size()) $display("FAIL rx_status_seen got %0d exp found", k);
        else begin
            n_pass++;
            n_tot++;
            if ({log_wr[k+1], log_addr[k+1]} !== {1'b0, 5'h00})
                $display("FAIL rx_read_addr got wr=%0b addr=%0h exp read 00", log_wr[k+1], log_addr[k+1]);
            else n_pass++;
            n_tot++; if (log_cyc[k+1] - log_cyc[k] != 2) $display("FAIL rx_read_lat got %0d exp 2", log_cyc[k+1] - log_cyc[k]); else n_pass++;
            n_tot++; if (rx_last_cyc - log_cyc[k+1] != 2) $display("FAIL rx_valid_lat got %0d exp 2", rx_last_cyc - log_cyc[k+1]); else n_pass++;
        end
    endtask

    task automatic test_arbitration();
        int lb, t;
        logic [4:0] ea [6];
        bit         ew [6];
        ea = '{5'h08, 5'h00, 5'h08, 5'h04, 5'h08, 5'h00};
        ew = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        lb = log_cyc.size();
        slv_rxdata = 16'h0011;
        tx_data = 8'h33; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        n_tot++; if (tx_ready !== 1'b0) $display("FAIL arb_tx_captured got %0b exp 0", tx_ready); else n_pass++;
        repeat (3) stat_q.push_back(16'h00C0);
        t = 0;
        while (log_cyc.size() < lb + 6 && t < 80) begin tick(); t++; end
        repeat (3) tick();
        n_tot++;
        if (log_cyc.size() < lb + 6) $display("FAIL arb_access_count got %0d exp 6", log_cyc.size() - lb);
        else begin
            n_pass++;
            for (int i = 0; i < 6; i++) begin
                n_tot++;
                if ({log_wr[lb+i], log_addr[lb+i]} !== {ew[i], ea[i]})
                    $display("FAIL arb_order%0d got wr=%0b addr=%0h exp wr=%0b addr=%0h", i, log_wr[lb+i], log_addr[lb+i], ew[i], ea[i]);
                else n_pass++;
            end
            n_tot++; if (log_data[lb+3] !== 16'h0033) $display("FAIL arb_tx_wdata got %0h exp 0033", log_data[lb+3]); else n_pass++;
            n_tot++;
            if (hist[log_cyc[lb+3]][1] !== 1'b0 || hist[log_cyc[lb+3] + 1][1] !== 1'b1)
                $display("FAIL arb_tx_ready_rise got %0b%0b exp 01", hist[log_cyc[lb+3]][1], hist[log_cyc[lb+3] + 1][1]);
            else n_pass++;
        end
        n_tot++; if (tx_ready !== 1'b1) $display("FAIL arb_tx_ready_end got %0b exp 1", tx_ready); else n_pass++;
    endtask

    task automatic test_overrun();
        int lb, t, k;
        n_tot++; if (ovf_count !== 8'h00) $display("FAIL ovr_start got %0d exp 0", ovf_count); else n_pass++;
        slv_wait = 3; stab_err = 0; both_err = 0; k = -1;
        lb = log_cyc.size();
        slv_rxdata = 16'h0077;
        stat_q.push_back(16'h0088);
        t = 0;
        while (ovf_count !== 8'h01 && t < 150) begin tick(); t++; end
        t = 0;
        while (busy !== 1'b0 && t < 150) begin tick(); t++; end
        n_tot++; if (ovf_count !== 8'h01) $display("FAIL ovr_count1 got %0d exp 1", ovf_count); else n_pass++;
        n_tot++; if (rx_data !== 8'h77) $display("FAIL ovr_rx_data got %0h exp 77", rx_data); else n_pass++;
        for (int i = lb; i < log_cyc.size(); i++)
            if (k < 0 && !log_wr[i] && log_addr[i] == 5'h08 && log_data[i] == 16'h0088) k = i;
        n_tot++;
        if (k < 0 || k + 2 >= log_cyc.size()) $display("FAIL ovr_seq_seen got %0d exp found", k);
        else begin
            n_pass++;
            n_tot++;
            if ({log_wr[k+1], log_addr[k+1]} !== {1'b0, 5'h00})
                $display("FAIL ovr_rx_read got wr=%0b addr=%0h exp read 00", log_wr[k+1], log_addr[k+1]);
            else n_pass++;
            n_tot++;
            if ({log_wr[k+2], log_addr[k+2], log_data[k+2]} !== {1'b1, 5'h08, 16'h0000})
                $display("FAIL ovr_clear got wr=%0b addr=%0h data=%0h exp write 08 0000", log_wr[k+2], log_addr[k+2], log_data[k+2]);
            else n_pass++;
            n_tot++;
            if (log_ws[k] != 3 || log_ws[k+1] != 3 || log_ws[k+2] != 3)
                $display("FAIL ovr_stalls got %0d %0d %0d exp 3 3 3", log_ws[k], log_ws[k+1], log_ws[k+2]);
            else n_pass++;
        end
        n_tot++; if (stab_err != 0) $display("FAIL ovr_bus_stable got %0d exp 0", stab_err); else n_pass++;
        n_tot++; if (both_err != 0) $display("FAIL ovr_both_strobes got %0d exp 0", both_err); else n_pass++;
        slv_wait = 0;
        repeat (299) stat_q.push_back(16'h0088);
        t = 0;
        while ((stat_q.size() > 0 || busy !== 1'b0) && t < 6000) begin tick(); t++; end
        n_tot++; if (ovf_count !== 8'hFF) $display("FAIL ovr_saturate got %0d exp 255", ovf_count); else n_pass++;
    endtask

    task automatic test_timeout();
        int t, p0, c, nx;
        slv_wait = 0; p0 = rx_pulses; nx = -1;
        slv_drop = 1'b1;
        t = 0;
        while (slv_drop && t < 50) begin tick(); t++; end
        c = drop_cyc;
        repeat (30) tick();
        n_tot++; if (hist[c+16][2] !== 1'b0) $display("FAIL to_err_early got %0b exp 0", hist[c+16][2]); else n_pass++;
        n_tot++; if (hist[c+17][2] !== 1'b1) $display("FAIL to_err_set got %0b exp 1", hist[c+17][2]); else n_pass++;
        n_tot++; if (hist[c+16][0] !== 1'b1) $display("FAIL to_busy_wait got %0b exp 1", hist[c+16][0]); else n_pass++;
        n_tot++; if (hist[c+17][0] !== 1'b0) $display("FAIL to_busy_idle got %0b exp 0", hist[c+17][0]); else n_pass++;
        for (int i = 0; i < log_cyc.size(); i++)
            if (nx < 0 && log_cyc[i] > c) nx = log_cyc[i];
        n_tot++; if (nx != c + 17 + PG + 1) $display("FAIL to_next_poll got %0d exp %0d", nx - c, 17 + PG + 1); else n_pass++;
        n_tot++; if (rx_pulses != p0) $display("FAIL to_no_rx_valid got %0d exp %0d", rx_pulses, p0); else n_pass++;
        n_tot++; if (err_timeout !== 1'b1) $display("FAIL to_sticky got %0b exp 1", err_timeout); else n_pass++;
    endtask

    task automatic test_reset_mid_tx();
        int t;
        slv_wait = 4;
        tx_data = 8'h44; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        t = 0;
        while (avm_write !== 1'b1 && t < 50) begin tick(); t++; end
        n_tot++;
        if ({avm_write, avm_address, avm_writedata} !== {1'b1, 5'h04, 16'h0044})
            $display("FAIL rt_tx_write got wr=%0b addr=%0h data=%0h exp 1 04 0044", avm_write, avm_address, avm_writedata);
        else n_pass++;
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_tot++; if (avm_write !== 1'b0) $display("FAIL rt_async_write got %0b exp 0", avm_write); else n_pass++;
        n_tot++; if (tx_ready !== 1'b1) $display("FAIL rt_tx_ready got %0b exp 1", tx_ready); else n_pass++;
        n_tot++; if (err_timeout !== 1'b0) $display("FAIL rt_err_clear got %0b exp 0", err_timeout); else n_pass++;
        tick();
        rst_n = 1'b1; slv_wait = 0;
        repeat (3) tick();
    endtask

    initial begin
        fork slave_proc(); join_none
        test_reset();
        test_idle_poll();
        test_rx_fetch();
        test_arbitration();
        test_overrun();
        test_timeout();
        test_reset_mid_tx();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d cycles", cyc);
        $fatal(1, "watchdog");
    end
endmodule
